// File: rtl/async_fifo_rd_stream.sv
// FIFO read-side output stage: turns rd_en/rd_empty into a registered FWFT valid/ready stream
// through a 2-entry skid buffer, with synchronous flush. Optional counters: ASYNC_FIFO_RD_STREAM_STATS_EN.
module async_fifo_rd_stream #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_rd_empty,
  input  logic                  flush,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [1:0]            occupancy
`ifdef ASYNC_FIFO_RD_STREAM_STATS_EN
  ,
  output logic [31:0]           stat_words,
  output logic [31:0]           stat_stall
`endif
);

  // Handshake: a word transfers on a rising edge where m_valid && m_ready; while
  // m_valid && !m_ready the head word and m_valid are held unchanged.

  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;
  logic [1:0]            occ_q, occ_d;
  logic                  inflight_q, inflight_d;
  logic                  valid_q, valid_d;

  logic       pop;
  logic [1:0] occ_after_pop;
  logic [2:0] committed;

  assign pop           = valid_q && m_ready;
  assign occ_after_pop = occ_q - {1'b0, pop};
  // Slots already spoken for once this edge's pop is taken into account.
  assign committed     = {1'b0, occ_after_pop} + {2'b00, inflight_q};

  assign fifo_rd_en = !fifo_rd_empty && !flush && !rd_rst && (committed < 3'd2);
  assign m_valid    = valid_q;
  assign m_data     = head_q;
  assign occupancy  = occ_q;

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    occ_d      = occ_q;
    inflight_d = inflight_q;
    valid_d    = valid_q;
    if (flush) begin
      occ_d      = 2'd0;
      valid_d    = 1'b0;
      inflight_d = 1'b0;
    end else begin
      inflight_d = fifo_rd_en;
      if (pop && (occ_q == 2'd2)) begin
        head_d = tail_q;
      end
      // The arriving word lands after the shift, in the first free slot.
      if (inflight_q) begin
        if (occ_after_pop == 2'd0) begin
          head_d = fifo_rd_data;
        end else begin
          tail_d = fifo_rd_data;
        end
      end
      occ_d   = committed[1:0];
      valid_d = (committed != 3'd0);
    end
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      valid_q    <= valid_d;
    end
  end

  a_no_overflow: assert property (@(posedge rd_clk) disable iff (rd_rst)
    (({1'b0, occ_q} + {2'b00, inflight_q}) <= 3'd2));

`ifdef ASYNC_FIFO_RD_STREAM_STATS_EN
  logic [31:0] words_q, stall_q;

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      words_q <= '0;
      stall_q <= '0;
    end else begin
      if (pop && !flush && (words_q != 32'hFFFF_FFFF)) begin
        words_q <= words_q + 32'd1;
      end
      if (valid_q && !m_ready && (stall_q != 32'hFFFF_FFFF)) begin
        stall_q <= stall_q + 32'd1;
      end
    end
  end

  assign stat_words = words_q;
  assign stat_stall = stall_q;
`endif

endmodule

// File: tb/tb_async_fifo_rd_stream.sv
// Bench for async_fifo_rd_stream: a queue-based FIFO model feeds the DUT, a monitor
// checks every stream transfer against the queue of issued words.
module tb_async_fifo_rd_stream;
  localparam int DW = 32;

  logic          rd_clk = 1'b0;
  logic          rd_rst = 1'b1;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_rd_data = '0;
  logic          fifo_rd_empty = 1'b1;
  logic          flush = 1'b0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic [1:0]    occupancy;
`ifdef ASYNC_FIFO_RD_STREAM_STATS_EN
  logic [31:0]   stat_words, stat_stall;
`endif

  async_fifo_rd_stream #(.DATA_WIDTH(DW)) dut (
    .rd_clk        (rd_clk),
    .rd_rst        (rd_rst),
    .fifo_rd_en    (fifo_rd_en),
    .fifo_rd_data  (fifo_rd_data),
    .fifo_rd_empty (fifo_rd_empty),
    .flush         (flush),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_data        (m_data),
    .occupancy     (occupancy)
`ifdef ASYNC_FIFO_RD_STREAM_STATS_EN
    ,
    .stat_words    (stat_words),
    .stat_stall    (stat_stall)
`endif
  );

  // Clock / watchdog
  always #5 rd_clk = ~rd_clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [DW-1:0] src_q[$];
  logic [DW-1:0] exp_q[$];
  int            n_vec = 0;
  int            n_err = 0;
  int            n_issue = 0;
  int            n_pop = 0;
  int unsigned   mdl_words = 0;
  int unsigned   mdl_stall = 0;
  bit            pend = 1'b0;
  logic [DW-1:0] pend_word = '0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock of stimulus; also acts as the FIFO model (data one cycle after an accepted read).
  task automatic cycle(input bit rdy, input bit gap, input bit fl, input bit rst);
    @(negedge rd_clk);
    fifo_rd_data  = pend ? pend_word : DW'($urandom);
    m_ready       = rdy;
    flush         = fl;
    rd_rst        = rst;
    fifo_rd_empty = (src_q.size() == 0) || gap;
    if (fl || rst) exp_q.delete();
    #1;
    pend = fifo_rd_en && !fifo_rd_empty;
    if (pend) begin
      pend_word = src_q.pop_front();
      exp_q.push_back(pend_word);
      n_issue++;
    end
  endtask

  task automatic drain(input int n);
    repeat (n) cycle(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: looks at the values the next rising edge will sample.
  initial begin : monitor
    bit            prev_stall;
    logic [DW-1:0] prev_data;
    prev_stall = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge rd_clk);
      #2;
      if (rd_rst) begin
        prev_stall = 1'b0;
        mdl_words  = 0;
        mdl_stall  = 0;
      end else begin
        if (prev_stall) begin
          check("stall_valid", DW'(m_valid), DW'(1));
          check("stall_data", m_data, prev_data);
        end
        check("occ_range", DW'(occupancy <= 2'd2), DW'(1));
        check("valid_vs_occ", DW'(m_valid), DW'(occupancy != 2'd0));
        if (m_valid && m_ready && !flush) begin
          n_pop++;
          mdl_words++;
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL pop_order: got %0h expected no word", m_data);
          end else begin
            check("pop_order", m_data, exp_q.pop_front());
          end
        end
        if (m_valid && !m_ready) mdl_stall++;
        prev_stall = m_valid && !m_ready && !flush;
        prev_data  = m_data;
      end
    end
  end

  initial begin : main
    int n0, p0, cyc;

    // Reset state
    repeat (3) cycle(1'b0, 1'b1, 1'b0, 1'b1);
    check("rst_valid", DW'(m_valid), DW'(0));
    check("rst_data", m_data, DW'(0));
    check("rst_occ", DW'(occupancy), DW'(0));
    check("rst_rd_en", DW'(fifo_rd_en), DW'(0));

    // Three words, consumer always ready
    src_q = '{32'h11, 32'h22, 32'h33};
    n0 = n_issue;
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check("t1_valid_c1", DW'(m_valid), DW'(0));
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check("t1_valid_c2", DW'(m_valid), DW'(0));
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check("t1_word0", m_data, 32'h11);
    check("t1_valid_c3", DW'(m_valid), DW'(1));
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check("t1_word1", m_data, 32'h22);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check("t1_word2", m_data, 32'h33);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check("t1_valid_end", DW'(m_valid), DW'(0));
    check("t1_issues", DW'(n_issue - n0), DW'(3));

    // Eight words with consumer stalled, then released
    for (int i = 0; i < 8; i++) src_q.push_back(32'hA000_0000 + DW'(i));
    n0 = n_issue;
    repeat (6) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check("t2_issues", DW'(n_issue - n0), DW'(2));
    check("t2_occ_full", DW'(occupancy), DW'(2));
    check("t2_head", m_data, 32'hA000_0000);
    p0 = n_pop;
    repeat (8) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check("t2_occ_tail", DW'(occupancy), DW'(1));
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check("t2_occ_empty", DW'(occupancy), DW'(0));
    check("t2_pops", DW'(n_pop - p0), DW'(8));
    check("t2_all_out", DW'(exp_q.size()), DW'(0));

    // Flush with one word held and one in flight
    src_q = '{32'hF1, 32'hF2, 32'hF3};
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    check("fl_occ_before", DW'(occupancy), DW'(1));
    check("fl_no_issue", DW'(fifo_rd_en), DW'(0));
    p0 = n_pop;
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check("fl_occ_after", DW'(occupancy), DW'(0));
    check("fl_valid_after", DW'(m_valid), DW'(0));
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check("fl_next_word", m_data, 32'hF3);
    drain(4);
    check("fl_pops", DW'(n_pop - p0), DW'(1));
    check("fl_all_out", DW'(exp_q.size()), DW'(0));

    // Reset while full; remaining FIFO words stream afterwards
    src_q = '{32'hB1, 32'hB2, 32'hB3, 32'hB4};
    repeat (4) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check("rm_occ_full", DW'(occupancy), DW'(2));
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    check("rm_rd_en_held", DW'(fifo_rd_en), DW'(0));
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    check("rm_valid", DW'(m_valid), DW'(0));
    check("rm_data", m_data, DW'(0));
    check("rm_occ", DW'(occupancy), DW'(0));
    check("rm_rd_en_held2", DW'(fifo_rd_en), DW'(0));
    p0 = n_pop;
    drain(6);
    check("rm_resume_pops", DW'(n_pop - p0), DW'(2));
    check("rm_all_out", DW'(exp_q.size()), DW'(0));

`ifdef ASYNC_FIFO_RD_STREAM_STATS_EN
    // Counters: 5 pops, 3 stall cycles, then a flush
    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) src_q.push_back(32'hC0 + DW'(i));
    repeat (5) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    drain(8);
    check("st_words", stat_words, 32'd5);
    check("st_stall", stat_stall, 32'd3);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check("st_words_flush", stat_words, 32'd5);
    check("st_stall_flush", stat_stall, 32'd3);
`endif

    // Randomised traffic: gaps, back-pressure, occasional flush
    for (int i = 0; i < 1000; i++) src_q.push_back(DW'($urandom));
    cyc = 0;
    while ((src_q.size() != 0 || exp_q.size() != 0) && cyc < 30000) begin
      cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 99) == 0), 1'b0);
      cyc++;
    end
    if (cyc >= 30000) begin
      n_vec++;
      n_err++;
      $display("FAIL rand_timeout: got %0d words left expected 0", src_q.size() + exp_q.size());
    end
    drain(3);
    check("rand_idle_valid", DW'(m_valid), DW'(0));
    check("rand_idle_occ", DW'(occupancy), DW'(0));
`ifdef ASYNC_FIFO_RD_STREAM_STATS_EN
    check("rand_stat_words", stat_words, mdl_words);
    check("rand_stat_stall", stat_stall, mdl_stall);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
